dump_loader: RTL and testbench

DUMP_LOADER -- requirements
Module: dump_loader

---
 rtl/dump_loader.sv | 101 ++++++++++
 tb/tb_dump_loader.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/dump_loader.sv
// dump_loader: streams PRG then CHR sector images from a byte source into target memories.
module dump_loader (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        load_dump,
  input  logic [31:0] dump_offset,
  input  logic [15:0] dump_prg_len,
  input  logic [15:0] dump_chr_len,
  output logic        rd_req,
  output logic [31:0] rd_sector,
  input  logic        rd_ack,
  input  logic [7:0]  rd_data,
  input  logic        rd_valid,
  output logic        rd_ready,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic        mem_sel,
  output logic [24:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, REQ, DATA, NEXT, DONE} state_t;
  state_t      state_q;
  logic [31:0] sector_q;
  logic [15:0] chr_q, rem_q, idx_q, rem_d;
  logic [8:0]  cnt_q;
  logic        phase_q, mem_we_q, mem_sel_q, done_q, take;
  logic [24:0] mem_addr_q;
  logic [7:0]  mem_data_q;
  assign take      = rd_valid & rd_ready;
  assign rem_d     = rem_q - 16'd1;
  assign rd_req    = state_q == REQ;
  assign rd_sector = sector_q;
  assign rd_ready  = (state_q == DATA) & mem_ready;
  assign mem_we    = mem_we_q;
  assign mem_sel   = mem_sel_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign done      = done_q;
  // The start cycle already counts as busy so the CPU is held from the accepting edge on.
  assign busy      = (state_q != IDLE) | (load_dump & reset);
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sector_q   <= '0;
      chr_q      <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_sel_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: if (load_dump) begin
          chr_q    <= dump_chr_len;
          sector_q <= dump_offset;
          idx_q    <= '0;
          phase_q  <= dump_prg_len == 16'd0;
          rem_q    <= dump_prg_len != 16'd0 ? dump_prg_len : dump_chr_len;
          state_q  <= (dump_prg_len == 16'd0 && dump_chr_len == 16'd0) ? DONE : REQ;
        end
        REQ: if (rd_ack) begin
          state_q <= DATA;
          cnt_q   <= '0;
        end
        DATA: if (take) begin
          mem_we_q   <= 1'b1;
          mem_data_q <= rd_data;
          mem_sel_q  <= phase_q;
          mem_addr_q <= {idx_q, cnt_q};
          cnt_q      <= cnt_q + 9'd1;
          if (cnt_q == 9'd511) state_q <= NEXT;
        end
        NEXT: begin
          sector_q <= sector_q + 32'd1;
          idx_q    <= idx_q + 16'd1;
          rem_q    <= rem_d;
          if (rem_d != 16'd0) state_q <= REQ;
          else if (!phase_q) begin
            phase_q <= 1'b1;
            idx_q   <= '0;
            rem_q   <= chr_q;
            state_q <= chr_q == 16'd0 ? DONE : REQ;
          end else state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dump_loader.sv
// tb_dump_loader: randomized source/memory handshakes checked against a per-load expected transfer list.
module tb_dump_loader;
  logic        sysclk = 0, reset = 0, load_dump = 0;
  logic [31:0] dump_offset = 0;
  logic [15:0] dump_prg_len = 0, dump_chr_len = 0;
  logic        rd_req, rd_ready, mem_we, mem_sel, busy, done;
  logic [31:0] rd_sector;
  logic        rd_ack = 0, rd_valid = 0, mem_ready = 0;
  logic [7:0]  rd_data = 0, mem_data;
  logic [24:0] mem_addr;
  int          vectors = 0, errors = 0, last_busy = 0;
  logic [7:0]  bytes[$];
  logic [33:0] exp_w[$];
  logic [31:0] exp_s[$];

  always #5 sysclk = ~sysclk;

  dump_loader dut (
    .sysclk(sysclk), .reset(reset), .load_dump(load_dump), .dump_offset(dump_offset),
    .dump_prg_len(dump_prg_len), .dump_chr_len(dump_chr_len), .rd_req(rd_req),
    .rd_sector(rd_sector), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .mem_ready(mem_ready), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected traffic: sector i of the load is off+i; PRG sectors first, CHR addresses restart at 0.
  task automatic build(input logic [31:0] off, input int prg, input int chr);
    logic       sel;
    int         idx;
    logic [7:0] d;
    bytes.delete(); exp_w.delete(); exp_s.delete();
    for (int i = 0; i < prg + chr; i++) begin
      sel = i >= prg;
      idx = sel ? i - prg : i;
      exp_s.push_back(off + 32'(i));
      for (int b = 0; b < 512; b++) begin
        d = 8'($urandom);
        bytes.push_back(d);
        exp_w.push_back({sel, 25'(idx * 512 + b), d});
      end
    end
  endtask

  task automatic run(input logic [31:0] off, input int prg, input int chr, input int vpct,
                     input int mpct, input int abort_at, input int repulse_at);
    int acks = 0, ptr = 0, dones = 0, busy_cyc = 0, done_cyc = -1;
    bit take = 0, prev_take = 0;
    build(off, prg, chr);
    @(negedge sysclk);
    rd_valid = 0; rd_ack = 0; mem_ready = 1;
    load_dump = 1; dump_offset = off; dump_prg_len = 16'(prg); dump_chr_len = 16'(chr);
    for (int cyc = 0; cyc < 60000 && dones == 0; cyc++) begin
      #1;
      if (abort_at >= 0 && ptr == abort_at) begin
        reset = 0;
        #1;
        check("rst_ctl", {rd_req, rd_ready, mem_we, mem_sel, busy, done}, 0);
        check("rst_sector", rd_sector, 0);
        check("rst_addr_data", {mem_addr, mem_data}, 0);
        rd_valid = 1;
        repeat (3) begin
          @(negedge sysclk); #1;
          check("rst_hold", {rd_req, rd_ready, mem_we, done, busy}, 0);
        end
        @(negedge sysclk);
        reset = 1; rd_valid = 0; rd_ack = 0;
        #1 check("rst_release_idle", {rd_req, busy, done}, 0);
        return;
      end
      busy_cyc += int'(busy);
      take = rd_valid & rd_ready;
      check("we_latency", mem_we, prev_take);
      if (rd_req) check("req_ready_excl", rd_ready, 0);
      if (rd_req && rd_ack) begin
        acks++;
        if (exp_s.size() == 0) check("extra_req", rd_sector, 64'hdead_0000_0000);
        else check("rd_sector", rd_sector, exp_s.pop_front());
      end
      if (mem_we) begin
        if (exp_w.size() == 0) check("extra_write", {mem_sel, mem_addr, mem_data}, 64'hdead_0000_0000);
        else check("write", {mem_sel, mem_addr, mem_data}, exp_w.pop_front());
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        check("busy_at_done", busy, 0);
      end
      prev_take = take;
      @(negedge sysclk);
      load_dump = (cyc + 1 == repulse_at);
      if (load_dump) begin
        dump_offset = off ^ 32'h5a5a; dump_prg_len += 3; dump_chr_len += 2;
      end
      if (take) ptr++;
      mem_ready = $urandom_range(99) < mpct;
      rd_ack = rd_req && ($urandom_range(99) < vpct);
      if (!(rd_valid && !take)) rd_valid = (ptr < acks * 512) && ($urandom_range(99) < vpct);
      if (rd_valid) rd_data = bytes[ptr];
    end
    #1;
    check("done_pulses", dones, 1);
    check("done_width", done, 0);
    check("busy_span", busy_cyc, done_cyc);
    check("writes_left", exp_w.size(), 0);
    check("reqs_left", exp_s.size(), 0);
    last_busy = busy_cyc;
    rd_valid = 0; rd_ack = 0;
  endtask

  initial begin
    repeat (2) @(negedge sysclk);
    #1;
    check("reset_ctl", {rd_req, rd_ready, mem_we, mem_sel, busy, done}, 0);
    check("reset_sector", rd_sector, 0);
    check("reset_addr_data", {mem_addr, mem_data}, 0);
    @(negedge sysclk);
    reset = 1;
    repeat (3) @(negedge sysclk);
    #1 check("idle_wait", {rd_req, busy, done, mem_we}, 0);
    run(32'h100, 64, 16, 100, 100, -1, -1);
    run(32'h2000, 0, 1, 100, 100, -1, -1);
    run(32'h55, 0, 0, 100, 100, -1, -1);
    check("zero_len_busy", last_busy, 2);
    run(32'h7000, 1, 1, 60, 55, -1, -1);
    run(32'hFFFF_FFFF, 2, 0, 80, 75, -1, -1);
    run(32'h300, 1, 2, 100, 100, -1, 200);
    run(32'h400, 2, 1, 100, 100, 300, -1);
    run(32'h400, 2, 1, 90, 85, -1, -1);
    for (int k = 0; k < 3; k++)
      run($urandom, $urandom_range(1), $urandom_range(1), $urandom_range(100, 50),
          $urandom_range(100, 50), -1, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
